id_operand_scoreboard: RTL and testbench
========================================

Name: id_operand_scoreboard

Overview:
- Next-generation operand-read and hazard unit for the ID stage.
- Generalises single-level ID/EX forwarding to FWD_STAGES prioritised forwarding sources.
- Replaces the fixed one-cycle load-use check with a per-register countdown scoreboard, sized for loads of configurable latency (LD_LAT).
- Registers the resolved operands into the ID/EX latch under stall/flush control. Sits between the GPR file and the decoder/EX stage.

Parameters:
- DATA_W, 32, operand width.
- REG_ADDR_W, 5, GPR address width; REG_NUM = 2**REG_ADDR_W.
- FWD_STAGES, 2, number of forwarding sources; index 0 is the youngest stage.
- LD_LAT, 1, cycles after load issue before its data appears on a forwarding bus; legal range 1..7.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_en  in  1  IF/ID holds a valid instruction
- ra_addr  in  REG_ADDR_W  operand A register
- rb_addr  in  REG_ADDR_W  operand B register
- gpr_rd_data_0  in  DATA_W  GPR read data, port A
- gpr_rd_data_1  in  DATA_W  GPR read data, port B
- fwd_en  in  FWD_STAGES  per-stage valid
- fwd_gpr_we_  in  FWD_STAGES  per-stage write enable, active low
- fwd_dst_addr  in  FWD_STAGES*REG_ADDR_W  per-stage destination; stage k occupies bits [k*REG_ADDR_W +: REG_ADDR_W]
- fwd_data  in  FWD_STAGES*DATA_W  per-stage result, same packing as fwd_dst_addr
- issue_gpr_we_  in  1  instruction in ID writes a GPR, active low
- issue_dst_addr  in  REG_ADDR_W  its destination register
- issue_is_load  in  1  the instruction in ID is a load
- stall  in  1  hold the ID/EX latch
- flush  in  1  kill the ID/EX latch and clear the scoreboard
- ra_data  out  DATA_W  resolved operand A (combinational)
- rb_data  out  DATA_W  resolved operand B (combinational)
- ld_hazard  out  1  load-use stall request (combinational)
- id_en  out  1  ID/EX latch valid (registered)
- id_ra_data  out  DATA_W  latched operand A
- id_rb_data  out  DATA_W  latched operand B
- sb_busy  out  1  any scoreboard counter is non-zero

Behaviour:
- Reset (synchronous, active-high, priority over all inputs):
  - All scoreboard counters = 0.
  - id_en = 0, id_ra_data = 0, id_rb_data = 0, sb_busy = 0.
- Forwarding, done separately for each operand:
  - Scan stages 0..FWD_STAGES-1 in order. The first stage k with fwd_en[k]=1, fwd_gpr_we_[k]=0 and a matching dst_addr supplies fwd_data[k].
  - If no stage matches, the operand is the GPR read data.
  - Only that stage's own gpr_we_ qualifies the match.
- Scoreboard:
  - One counter of width clog2(LD_LAT+1) per GPR.
  - Define issue = if_en & ~ld_hazard & ~stall & ~flush.
  - Load issue: if issue & issue_is_load & ~issue_gpr_we_, counter[issue_dst_addr] <= LD_LAT at the next edge.
  - Every other non-zero counter decrements by 1 each cycle.
  - Stall does not freeze the counters; in-flight loads keep advancing.
  - Same-register collision: a load issue to a register whose counter is also decrementing takes priority and reloads it to LD_LAT.
  - Flush clears all counters to 0. Flush is raised only when downstream loads are killed as well.
- ld_hazard = if_en & ((counter[ra_addr] != 0) | (counter[rb_addr] != 0)).
  - Both counters are read before the clock edge.
  - With LD_LAT=1, the hazard lasts exactly one cycle after the load issues.
- sb_busy = OR over all counters, registered. It reflects the counter state after the current edge.
- ID/EX latch, priority order:
  1. reset
  2. flush: id_en <= 0; data registers hold
  3. stall: all latch registers hold
  4. otherwise: id_en <= if_en & ~ld_hazard; id_ra_data <= ra_data; id_rb_data <= rb_data
- A hazard bubble inserts id_en=0. The data registers still load, but their contents are don't-care.
- Reset mid-operation discards all pending loads. The first cycle after reset issues no hazard.

Optional Feature:
- Macro: ID_ZERO_REG_EN.
- Defined:
  - Register 0 reads as 0 regardless of GPR or forwarding data.
  - Register 0 never raises ld_hazard.
  - Load issues to register 0 do not load the scoreboard.
- Undefined: register 0 is an ordinary register in forwarding and scoreboarding.

Test Plan:
- Forwarding priority (FWD_STAGES=2): stage0 writes r3=0x11, stage1 writes r3=0x22, ra_addr=3, gpr_rd_data_0=0x33 -> ra_data=0x11.
  - Disable stage0 -> ra_data=0x22.
  - Set fwd_gpr_we_[1]=1 -> ra_data=0x33.
- Load-use (LD_LAT=1): issue load r5 at cycle t, next instruction reads rb=5 -> ld_hazard=1 in t+1 and id_en=0 at t+2. Cycle t+2: ld_hazard=0, rb_data taken from stage1 data.
- Long latency (LD_LAT=3): load r7 issues at t -> ld_hazard for a reader of r7 during t+1..t+3, clear at t+4. sb_busy=1 from t+1 to t+3.
- Stall during countdown (LD_LAT=3): hold stall=1 from t+1 to t+4 -> id_ra_data/id_rb_data/id_en unchanged, and the counter still reaches 0 at t+4.
- Flush and reset: issue load r9 (LD_LAT=3), then flush at t+1 -> ld_hazard=0 and sb_busy=0 at t+2. Repeat with reset -> all outputs 0 the next cycle.
- ID_ZERO_REG_EN: stage0 writes r0=0xFFFF_FFFF, ra_addr=0 -> ra_data=0. A load to r0 then a read of r0 -> ld_hazard=0.

Source files
------------

// File: rtl/id_operand_scoreboard.sv
// ID-stage operand resolution with prioritised forwarding, a per-register load
// countdown scoreboard and the ID/EX operand latch. Optional: ID_ZERO_REG_EN.
module id_operand_scoreboard #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int FWD_STAGES = 2,
  parameter int LD_LAT     = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             if_en,
  input  logic [REG_ADDR_W-1:0]            ra_addr,
  input  logic [REG_ADDR_W-1:0]            rb_addr,
  input  logic [DATA_W-1:0]                gpr_rd_data_0,
  input  logic [DATA_W-1:0]                gpr_rd_data_1,
  input  logic [FWD_STAGES-1:0]            fwd_en,
  input  logic [FWD_STAGES-1:0]            fwd_gpr_we_,
  input  logic [FWD_STAGES*REG_ADDR_W-1:0] fwd_dst_addr,
  input  logic [FWD_STAGES*DATA_W-1:0]     fwd_data,
  input  logic                             issue_gpr_we_,
  input  logic [REG_ADDR_W-1:0]            issue_dst_addr,
  input  logic                             issue_is_load,
  input  logic                             stall,
  input  logic                             flush,
  output logic [DATA_W-1:0]                ra_data,
  output logic [DATA_W-1:0]                rb_data,
  output logic                             ld_hazard,
  output logic                             id_en,
  output logic [DATA_W-1:0]                id_ra_data,
  output logic [DATA_W-1:0]                id_rb_data,
  output logic                             sb_busy
);

  localparam int REG_NUM = 2 ** REG_ADDR_W;
  localparam int CNT_W   = $clog2(LD_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LD_LAT);

  logic [CNT_W-1:0] sb_cnt [REG_NUM];
  logic [CNT_W-1:0] sb_nxt [REG_NUM];
  logic             any_nxt;
  logic             ra_pend, rb_pend;
  logic             issue, ld_issue;

  // Walk from the oldest stage to the youngest so the youngest match wins.
  function automatic logic [DATA_W-1:0] resolve(
    input logic [REG_ADDR_W-1:0]            addr,
    input logic [DATA_W-1:0]                gpr,
    input logic [FWD_STAGES-1:0]            en,
    input logic [FWD_STAGES-1:0]            we_,
    input logic [FWD_STAGES*REG_ADDR_W-1:0] dst,
    input logic [FWD_STAGES*DATA_W-1:0]     data
  );
    logic [DATA_W-1:0] res;
    res = gpr;
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (en[k] && !we_[k] && (dst[k*REG_ADDR_W +: REG_ADDR_W] == addr))
        res = data[k*DATA_W +: DATA_W];
    end
`ifdef ID_ZERO_REG_EN
    if (addr == '0) res = '0;
`endif
    return res;
  endfunction

  always_comb begin
    ra_data = resolve(ra_addr, gpr_rd_data_0, fwd_en, fwd_gpr_we_, fwd_dst_addr, fwd_data);
    rb_data = resolve(rb_addr, gpr_rd_data_1, fwd_en, fwd_gpr_we_, fwd_dst_addr, fwd_data);
  end

  always_comb begin
    ra_pend = (sb_cnt[ra_addr] != '0);
    rb_pend = (sb_cnt[rb_addr] != '0);
`ifdef ID_ZERO_REG_EN
    if (ra_addr == '0) ra_pend = 1'b0;
    if (rb_addr == '0) rb_pend = 1'b0;
`endif
    ld_hazard = if_en & (ra_pend | rb_pend);
    issue     = if_en & ~ld_hazard & ~stall & ~flush;
    ld_issue  = issue & issue_is_load & ~issue_gpr_we_;
`ifdef ID_ZERO_REG_EN
    if (issue_dst_addr == '0) ld_issue = 1'b0;
`endif
  end

  // NOTE: every combinational output gets a default before any conditional
  // override; otherwise a path that skips the assignment infers a latch.
  always_comb begin
    any_nxt = 1'b0;
    for (int r = 0; r < REG_NUM; r++) begin
      sb_nxt[r] = (sb_cnt[r] != '0) ? sb_cnt[r] - CNT_W'(1) : '0;
      if (flush)
        sb_nxt[r] = '0;
      else if (ld_issue && (issue_dst_addr == REG_ADDR_W'(r)))
        sb_nxt[r] = CNT_LOAD;
      any_nxt = any_nxt | (sb_nxt[r] != '0);
    end
  end

  // NOTE: the counter array is ordinary flops, not a RAM, so it is reset; a
  // stale count surviving reset would raise a phantom hazard.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < REG_NUM; r++) sb_cnt[r] <= '0;
      sb_busy <= 1'b0;
    end else begin
      for (int r = 0; r < REG_NUM; r++) sb_cnt[r] <= sb_nxt[r];
      sb_busy <= any_nxt;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples values
  // from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_en      <= 1'b0;
      id_ra_data <= '0;
      id_rb_data <= '0;
    end else if (flush) begin
      id_en <= 1'b0;
    end else if (!stall) begin
      id_en      <= if_en & ~ld_hazard;
      id_ra_data <= ra_data;
      id_rb_data <= rb_data;
    end
  end

endmodule

// File: tb/tb_id_operand_scoreboard.sv
// Scoreboard bench: stimulus pushes per-cycle expectations into a queue; a
// negedge monitor pops and compares them. Two DUTs: LD_LAT=1 and LD_LAT=3.
module tb_id_operand_scoreboard;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int FS = 2;

  typedef enum {RA1, RB1, HAZ1, IDEN1, IDRA1, IDRB1, BUSY1,
                HAZ3, IDEN3, IDRA3, IDRB3, BUSY3} sig_e;

  typedef struct {
    int          cyc;
    sig_e        sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            if_en;
  logic [AW-1:0]   ra_addr, rb_addr;
  logic [DW-1:0]   gpr_rd_data_0, gpr_rd_data_1;
  logic [FS-1:0]   fwd_en, fwd_gpr_we_;
  logic [FS*AW-1:0] fwd_dst_addr;
  logic [FS*DW-1:0] fwd_data;
  logic            issue_gpr_we_;
  logic [AW-1:0]   issue_dst_addr;
  logic            issue_is_load;
  logic            stall, flush;

  logic [DW-1:0] ra_data_1, rb_data_1, id_ra_data_1, id_rb_data_1;
  logic          ld_hazard_1, id_en_1, sb_busy_1;
  logic [DW-1:0] ra_data_3, rb_data_3, id_ra_data_3, id_rb_data_3;
  logic          ld_hazard_3, id_en_3, sb_busy_3;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  id_operand_scoreboard #(.DATA_W(DW), .REG_ADDR_W(AW), .FWD_STAGES(FS), .LD_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .if_en(if_en), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .gpr_rd_data_0(gpr_rd_data_0), .gpr_rd_data_1(gpr_rd_data_1),
    .fwd_en(fwd_en), .fwd_gpr_we_(fwd_gpr_we_), .fwd_dst_addr(fwd_dst_addr), .fwd_data(fwd_data),
    .issue_gpr_we_(issue_gpr_we_), .issue_dst_addr(issue_dst_addr), .issue_is_load(issue_is_load),
    .stall(stall), .flush(flush), .ra_data(ra_data_1), .rb_data(rb_data_1),
    .ld_hazard(ld_hazard_1), .id_en(id_en_1), .id_ra_data(id_ra_data_1),
    .id_rb_data(id_rb_data_1), .sb_busy(sb_busy_1)
  );

  id_operand_scoreboard #(.DATA_W(DW), .REG_ADDR_W(AW), .FWD_STAGES(FS), .LD_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset), .if_en(if_en), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .gpr_rd_data_0(gpr_rd_data_0), .gpr_rd_data_1(gpr_rd_data_1),
    .fwd_en(fwd_en), .fwd_gpr_we_(fwd_gpr_we_), .fwd_dst_addr(fwd_dst_addr), .fwd_data(fwd_data),
    .issue_gpr_we_(issue_gpr_we_), .issue_dst_addr(issue_dst_addr), .issue_is_load(issue_is_load),
    .stall(stall), .flush(flush), .ra_data(ra_data_3), .rb_data(rb_data_3),
    .ld_hazard(ld_hazard_3), .id_en(id_en_3), .id_ra_data(id_ra_data_3),
    .id_rb_data(id_rb_data_3), .sb_busy(sb_busy_3)
  );

  function automatic logic [31:0] act(input sig_e s);
    case (s)
      RA1:   return ra_data_1;
      RB1:   return rb_data_1;
      HAZ1:  return {31'd0, ld_hazard_1};
      IDEN1: return {31'd0, id_en_1};
      IDRA1: return id_ra_data_1;
      IDRB1: return id_rb_data_1;
      BUSY1: return {31'd0, sb_busy_1};
      HAZ3:  return {31'd0, ld_hazard_3};
      IDEN3: return {31'd0, id_en_3};
      IDRA3: return id_ra_data_3;
      IDRB3: return id_rb_data_3;
      BUSY3: return {31'd0, sb_busy_3};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: compare every expectation due this cycle; late ones count as errors.
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        check(q[i].name, act(q[i].sig), q[i].val);
        q.delete(i);
      end else if (q[i].cyc < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d never compared", q[i].name, q[i].cyc);
        q.delete(i);
      end
    end
  end

  task automatic push_exp(input int dly, input sig_e s, input logic [31:0] v, input string n);
    exp_t e;
    e.cyc = cyc + dly; e.sig = s; e.val = v; e.name = n;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_en = 0; ra_addr = '0; rb_addr = '0; gpr_rd_data_0 = '0; gpr_rd_data_1 = '0;
    fwd_en = '0; fwd_gpr_we_ = '1; fwd_dst_addr = '0; fwd_data = '0;
    issue_gpr_we_ = 1; issue_dst_addr = '0; issue_is_load = 0; stall = 0; flush = 0;
  endtask

  task automatic issue_load(input logic [AW-1:0] dst);
    if_en = 1; issue_is_load = 1; issue_gpr_we_ = 0; issue_dst_addr = dst;
  endtask

  task automatic no_load();
    issue_is_load = 0; issue_gpr_we_ = 1;
  endtask

  initial begin
    idle();
    reset = 1;
    step(); step();
    reset = 0;
    push_exp(0, IDEN1, 0, "rst_id_en"); push_exp(0, IDRA1, 0, "rst_id_ra");
    push_exp(0, IDRB1, 0, "rst_id_rb"); push_exp(0, BUSY1, 0, "rst_busy");
    push_exp(0, HAZ1, 0, "rst_haz");    push_exp(0, BUSY3, 0, "rst_busy3");

    // Forwarding priority
    step();
    if_en = 1; ra_addr = 3; rb_addr = 4; gpr_rd_data_0 = 32'h33; gpr_rd_data_1 = 32'h44;
    fwd_en = 2'b11; fwd_gpr_we_ = 2'b00; fwd_dst_addr = {5'd3, 5'd3}; fwd_data = {32'h22, 32'h11};
    push_exp(0, RA1, 32'h11, "fwd_s0_wins"); push_exp(0, RB1, 32'h44, "fwd_rb_gpr");
    push_exp(1, IDRA1, 32'h11, "fwd_latch_ra"); push_exp(1, IDEN1, 1, "fwd_latch_en");
    step();
    fwd_en = 2'b10;
    push_exp(0, RA1, 32'h22, "fwd_s1");
    step();
    fwd_gpr_we_ = 2'b10;
    push_exp(0, RA1, 32'h33, "fwd_none"); push_exp(1, IDRA1, 32'h33, "fwd_latch_gpr");
    step();
    fwd_en = 2'b11; fwd_gpr_we_ = 2'b01; rb_addr = 3; gpr_rd_data_1 = 32'h55;
    push_exp(0, RB1, 32'h22, "fwd_own_we"); push_exp(0, RA1, 32'h22, "fwd_own_we_ra");
    step();
    idle();

    // Load-use, LD_LAT=1
    step();
    ra_addr = 1; rb_addr = 2; issue_load(5);
    push_exp(0, HAZ1, 0, "lu_t_nohaz");
    step();
    no_load(); rb_addr = 5;
    push_exp(0, HAZ1, 1, "lu_haz_t1"); push_exp(0, BUSY1, 1, "lu_busy_t1");
    step();
    fwd_en = 2'b10; fwd_gpr_we_ = 2'b01; fwd_dst_addr = {5'd5, 5'd0}; fwd_data = {32'hABCD, 32'h0};
    push_exp(0, HAZ1, 0, "lu_haz_t2"); push_exp(0, IDEN1, 0, "lu_bubble");
    push_exp(0, RB1, 32'hABCD, "lu_fwd_s1"); push_exp(0, BUSY1, 0, "lu_busy_t2");
    push_exp(1, IDEN1, 1, "lu_resume"); push_exp(1, IDRB1, 32'hABCD, "lu_latch_rb");
    step();
    idle();
    repeat (4) step();

    // Long latency, LD_LAT=3
    ra_addr = 1; rb_addr = 2; issue_load(7);
    step();
    no_load(); ra_addr = 7;
    push_exp(0, HAZ3, 1, "ll_haz_t1"); push_exp(0, BUSY3, 1, "ll_busy_t1");
    push_exp(0, HAZ1, 1, "ll_lat1_haz_t1");
    step();
    push_exp(0, HAZ3, 1, "ll_haz_t2"); push_exp(0, BUSY3, 1, "ll_busy_t2");
    push_exp(0, HAZ1, 0, "ll_lat1_clear"); push_exp(0, IDEN3, 0, "ll_bubble");
    step();
    push_exp(0, HAZ3, 1, "ll_haz_t3"); push_exp(0, BUSY3, 1, "ll_busy_t3");
    step();
    push_exp(0, HAZ3, 0, "ll_haz_t4"); push_exp(0, BUSY3, 0, "ll_busy_t4");
    push_exp(1, IDEN3, 1, "ll_resume");
    step();
    idle();
    step();

    // Stall during countdown, LD_LAT=3
    ra_addr = 1; rb_addr = 2; gpr_rd_data_0 = 32'hA1; gpr_rd_data_1 = 32'hB2; issue_load(7);
    step();
    no_load(); stall = 1; ra_addr = 7; gpr_rd_data_0 = 32'hC3; gpr_rd_data_1 = 32'hD4;
    push_exp(0, IDEN3, 1, "st_latch_en"); push_exp(0, IDRA3, 32'hA1, "st_latch_ra");
    push_exp(0, IDRB3, 32'hB2, "st_latch_rb");
    step();
    push_exp(0, IDRA3, 32'hA1, "st_hold_ra2"); push_exp(0, IDEN3, 1, "st_hold_en2");
    step();
    push_exp(0, IDRB3, 32'hB2, "st_hold_rb3"); push_exp(0, HAZ3, 1, "st_haz_t3");
    step();
    push_exp(0, HAZ3, 0, "st_cnt_zero"); push_exp(0, BUSY3, 0, "st_busy_t4");
    push_exp(0, IDRA3, 32'hA1, "st_hold_ra4"); push_exp(0, IDEN3, 1, "st_hold_en4");
    step();
    stall = 0;
    push_exp(0, IDRA3, 32'hA1, "st_hold_ra5");
    push_exp(1, IDRA3, 32'hC3, "st_resume_ra"); push_exp(1, IDEN3, 1, "st_resume_en");
    step();
    idle();
    step();

    // Flush
    ra_addr = 1; rb_addr = 2; issue_load(9);
    step();
    no_load(); flush = 1; rb_addr = 9;
    push_exp(0, HAZ3, 1, "fl_haz_t1"); push_exp(0, IDEN3, 1, "fl_issued");
    step();
    flush = 0;
    push_exp(0, HAZ3, 0, "fl_haz_t2"); push_exp(0, BUSY3, 0, "fl_busy_t2");
    push_exp(0, IDEN3, 0, "fl_kill");
    step();
    idle();
    step();

    // Reset mid-operation
    ra_addr = 1; rb_addr = 2; gpr_rd_data_0 = 32'h77; issue_load(9);
    step();
    no_load(); reset = 1; rb_addr = 9;
    push_exp(0, IDRA3, 32'h77, "rs_pre_ra");
    step();
    reset = 0;
    push_exp(0, HAZ3, 0, "rs_haz"); push_exp(0, BUSY3, 0, "rs_busy");
    push_exp(0, IDEN3, 0, "rs_id_en"); push_exp(0, IDRA3, 0, "rs_id_ra");
    push_exp(0, IDRB3, 0, "rs_id_rb"); push_exp(0, IDEN1, 0, "rs_id_en1");
    step();
    idle();
    step();

    // Register 0
    ra_addr = 0; rb_addr = 2; gpr_rd_data_0 = 32'h12;
    fwd_en = 2'b01; fwd_gpr_we_ = 2'b10; fwd_dst_addr = '0; fwd_data = {32'h0, 32'hFFFF_FFFF};
    issue_load(0);
`ifdef ID_ZERO_REG_EN
    push_exp(0, RA1, 32'h0, "r0_fwd");
`else
    push_exp(0, RA1, 32'hFFFF_FFFF, "r0_fwd");
`endif
    step();
    no_load(); fwd_en = '0; fwd_gpr_we_ = '1;
`ifdef ID_ZERO_REG_EN
    push_exp(0, HAZ1, 0, "r0_haz");
`else
    push_exp(0, HAZ1, 1, "r0_haz");
`endif
    step();
    idle();
    repeat (3) step();

    for (int i = 0; i < q.size(); i++) begin
      errors++;
      $display("FAIL %s: expectation left unchecked", q[i].name);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
